// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-style controller: FSM states,
// opcodes, ALU/mux select codes and the bundled control-word type.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// Combinational state-to-control decoder. Only pc_en and ir_write look at
// live inputs; every other field is a pure function of the state.
module mc_out_dec
  import multi_cycle_control_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  input  logic   i_ori,
  output ctrl_t  o_ctrl
);

  // Per-state control word; anything not set stays 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.pc_en     = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      S_DECODE:  o_ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:   o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_OUT;
        o_ctrl.pc_en     = i_zero;
      end
      S_IMMEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.ext_zero  = i_ori;
        if (i_ori) begin
          o_ctrl.alu_op = ALUOP_OR;
        end else begin
          o_ctrl.alu_op = ALUOP_ADD;
        end
      end
      S_IMMWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.ext_zero  = i_ori;
      end
      S_JEX: begin
        o_ctrl.pc_src = PCSRC_JUMP;
        o_ctrl.pc_en  = 1'b1;
      end
      S_ILLEGAL: o_ctrl.illegal = 1'b1;
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle controller FSM (state register + next-state logic).
// Define ORI_IMM_EN to accept ori (zero-extended immediate OR) via IMMEX/IMMWB.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_zero,
  output logic       illegal
);

  state_t r_state;
  state_t w_next;
  logic   w_ori;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef ORI_IMM_EN
  logic r_ori;

  // Remember at DECODE whether the immediate op is ori, so IMMEX/IMMWB stay state-decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ori <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_ori <= (opcode == OP_ORI);
    end else begin
      r_ori <= r_ori;
    end
  end

  assign w_ori = r_ori;
`else
  assign w_ori = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_IMMEX;
`ifdef ORI_IMM_EN
          OP_ORI:       w_next = S_IMMEX;
`endif
          OP_J:         w_next = S_JEX;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_IMMEX:   w_next = S_IMMWB;
      S_ILLEGAL: w_next = S_ILLEGAL;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX: w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  mc_out_dec u_dec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .i_ori       (w_ori),
    .o_ctrl      (w_ctrl)
  );

  // Reset blanks the control word at once so no strobe escapes the asserting edge.
  assign w_out = reset ? ctrl_t'('0) : w_ctrl;

  assign pc_en      = w_out.pc_en;
  assign iord       = w_out.iord;
  assign mem_write  = w_out.mem_write;
  assign ir_write   = w_out.ir_write;
  assign reg_write  = w_out.reg_write;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_op     = w_out.alu_op;
  assign pc_src     = w_out.pc_src;
  assign ext_zero   = w_out.ext_zero;
  assign illegal    = w_out.illegal;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle
// control words from the instruction table; a monitor compares every cycle.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;

  multi_cycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .ext_zero   (ext_zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Control-word bit masks: {pc_en,iord,mem_write,ir_write,reg_write,reg_dst,
  // mem_to_reg,alu_src_a,alu_src_b[2],alu_op[2],pc_src[2],ext_zero,illegal}
  localparam logic [15:0] PCEN    = 16'h8000;
  localparam logic [15:0] IORD    = 16'h4000;
  localparam logic [15:0] MEMW    = 16'h2000;
  localparam logic [15:0] IRW     = 16'h1000;
  localparam logic [15:0] REGW    = 16'h0800;
  localparam logic [15:0] REGDST  = 16'h0400;
  localparam logic [15:0] M2R     = 16'h0200;
  localparam logic [15:0] SRCA    = 16'h0100;
  localparam logic [15:0] SB_4    = 16'h0040;
  localparam logic [15:0] SB_IMM  = 16'h0080;
  localparam logic [15:0] SB_SH   = 16'h00C0;
  localparam logic [15:0] A_SUB   = 16'h0010;
  localparam logic [15:0] A_FUNCT = 16'h0020;
  localparam logic [15:0] A_OR    = 16'h0030;
  localparam logic [15:0] PC_OUT  = 16'h0004;
  localparam logic [15:0] PC_JMP  = 16'h0008;
  localparam logic [15:0] EXTZ    = 16'h0002;
  localparam logic [15:0] ILL     = 16'h0001;
  localparam logic [15:0] NONE    = 16'h0000;

  logic [15:0] w_act;
  assign w_act = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, illegal};

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  // Push one expected cycle, then let that cycle elapse.
  task automatic cycle(input logic [15:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Cycle in which mem_ready and zero are don't-cares: randomize them.
  task automatic step(input logic [15:0] e, input string t);
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    cycle(e, t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(NONE, "reset");
    step(NONE, "reset");
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fstall,
                           input int mstall, input logic abort_ex);
    for (int i = 0; i < fstall; i++) begin
      opcode    = 6'($urandom_range(0, 63));
      mem_ready = 1'b0;
      zero      = 1'($urandom);
      cycle(SB_4, "fetch_wait");
    end
    opcode    = 6'($urandom_range(0, 63));
    mem_ready = 1'b1;
    zero      = 1'($urandom);
    cycle(PCEN | IRW | SB_4, "fetch");
    opcode = op;
    step(SB_SH, "decode");
    if (abort_ex) begin
      reset = 1'b1;
      step(NONE, "abort");
      step(NONE, "abort");
      reset = 1'b0;
      return;
    end
    case (op)
      6'b100011: begin
        step(SRCA | SB_IMM, "lw_memadr");
        for (int i = 0; i < mstall; i++) begin
          mem_ready = 1'b0;
          zero      = 1'($urandom);
          cycle(IORD, "memrd_wait");
        end
        mem_ready = 1'b1;
        cycle(IORD, "memrd");
        step(M2R | REGW, "memwb");
      end
      6'b101011: begin
        step(SRCA | SB_IMM, "sw_memadr");
        for (int i = 0; i < mstall; i++) begin
          mem_ready = 1'b0;
          zero      = 1'($urandom);
          cycle(IORD | MEMW, "memwr_wait");
        end
        mem_ready = 1'b1;
        cycle(IORD | MEMW, "memwr");
      end
      6'b000000: begin
        step(SRCA | A_FUNCT, "rtypeex");
        step(REGDST | REGW, "rtypewb");
      end
      6'b000100: begin
        mem_ready = 1'($urandom);
        zero      = z;
        cycle(SRCA | A_SUB | PC_OUT | (z ? PCEN : NONE), "beqex");
      end
      6'b001000: begin
        step(SRCA | SB_IMM, "addi_ex");
        step(REGW, "addi_wb");
      end
`ifdef ORI_IMM_EN
      6'b001101: begin
        step(SRCA | SB_IMM | A_OR | EXTZ, "ori_ex");
        step(REGW | EXTZ, "ori_wb");
      end
`endif
      6'b000010: step(PCEN | PC_JMP, "jex");
      default: begin
        for (int i = 0; i < 20 + int'($urandom_range(0, 4)); i++) begin
          opcode = 6'($urandom_range(0, 63));
          step(ILL, "illegal");
        end
        do_reset();
      end
    endcase
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    logic [15:0] e;
    string       t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (w_act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", t, w_act, e, $time);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops[7];
    int         k;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b001101;
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_instr(6'b100011, 1'b0, 0, 0, 1'b0);
    run_instr(6'b101011, 1'b0, 0, 3, 1'b0);
    run_instr(6'b000100, 1'b1, 0, 0, 1'b0);
    run_instr(6'b000100, 1'b0, 1, 0, 1'b0);
    run_instr(6'b000000, 1'b0, 0, 0, 1'b1);
    run_instr(6'b000000, 1'b0, 0, 0, 1'b0);
    run_instr(6'b001101, 1'b0, 0, 0, 1'b0);
    run_instr(6'b111111, 1'b0, 0, 0, 1'b0);
    run_instr(6'b001000, 1'b0, 2, 0, 1'b0);
    run_instr(6'b000010, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 7) begin
        run_instr(ops[k], 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      end else begin
        run_instr(6'($urandom_range(0, 63)), 1'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'b0);
      end
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameters: none; all encodings come from the shared definitions file.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state FETCH and all outputs 0.
REQ-004 opcode  input  6  instr[31:26] from instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_en  output  1  PC register load enable.
REQ-008 iord  output  1  memory address mux: 0 = PC, 1 = ALUOut.
REQ-009 mem_write, ir_write, reg_write  output  1 each  write strobes.
REQ-010 reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-011 alu_src_b  output  2  00 = reg B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
REQ-012 alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = or.
REQ-013 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 ext_zero  output  1  immediate extender: 1 = zero-extend, 0 = sign-extend.
REQ-015 illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-016 Moore FSM; all outputs decoded from state only, except pc_en (FETCH: mem_ready; BEQEX: zero) and ir_write (FETCH: mem_ready).
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX, ILLEGAL.
REQ-018 Unlisted outputs are 0 in every state.
REQ-019 FETCH: iord=0, alu_src_b=01, alu_op=00, pc_src=00; holds while mem_ready=0; -> DECODE on mem_ready=1.
REQ-020 DECODE: alu_src_b=11, alu_op=00; lw 100011/sw 101011 -> MEMADR; R 000000 -> RTYPEEX; beq 000100 -> BEQEX; addi 001000 -> IMMEX; j 000010 -> JEX; others -> ILLEGAL.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10; lw -> MEMRD, sw -> MEMWR.
REQ-022 MEMRD: iord=1; holds until mem_ready=1, then -> MEMWB.
REQ-023 MEMWB: mem_to_reg=1, reg_write=1; -> FETCH.
REQ-024 MEMWR: iord=1, mem_write=1 held until mem_ready=1; -> FETCH.
REQ-025 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10; -> RTYPEWB: reg_dst=1, reg_write=1; -> FETCH.
REQ-026 BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; -> FETCH.
REQ-027 IMMEX: alu_src_a=1, alu_src_b=10, alu_op=00; -> IMMWB: reg_write=1; -> FETCH.
REQ-028 JEX: pc_src=10, pc_en=1; -> FETCH.
REQ-029 ILLEGAL: illegal=1, all strobes 0; absorbing until reset.
REQ-030 Latency with mem_ready=1: lw 5, sw/R/addi 4, beq/j 3 cycles.

Reset
REQ-031 Reset assertion mid-instruction aborts immediately: no write strobe after the asserting edge; illegal cleared.
REQ-032 First FETCH begins on the first rising clk after reset deasserts.

Configuration
REQ-033 Macro ORI_IMM_EN defined: ori 001101 -> IMMEX with alu_op=11 and ext_zero=1 in IMMEX and IMMWB.
REQ-034 Macro ORI_IMM_EN undefined: 001101 -> ILLEGAL; ext_zero is constant 0.

Structure
REQ-035 Shared definitions file holds state encodings, opcode constants, alu_op and alu_src_b codes.
REQ-036 One sub-module, mc_out_dec: combinational state-to-output decoder; the FSM register and next-state logic stay in multi_cycle_control.

Verification
REQ-037 Reset high, then release; opcode=100011, mem_ready=1 -> DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-038 sw 101011 with mem_ready low for 3 cycles in MEMWR -> mem_write=1 held for 4 cycles, single return to FETCH.
REQ-039 beq 000100: zero=1 -> pc_en=1, pc_src=01 in BEQEX; zero=0 -> pc_en=0.
REQ-040 Opcode 111111 -> ILLEGAL, illegal=1 for 20+ cycles, strobes 0; reset -> FETCH, illegal=0.
REQ-041 Reset asserted mid-RTYPEEX -> reg_write never asserted; restart at FETCH.
REQ-042 Opcode 001101: with ORI_IMM_EN -> alu_op=11, ext_zero=1, reg_write in IMMWB; without -> illegal=1.
